m_pc_gen_ras: RTL and testbench

// - Parametrised next-generation PC generator for the fetch stage: holds architectural fetch PC, applies redirects by fixed priority.
// - Adds fetch valid/ready handshake, sign-extended branch offsets and a RAS_DEPTH-entry return-address stack (call/ret).
// - Sits between decode/execute redirect logic and the I-cache request port.

---
 rtl/m_pc_gen_ras_pkg.sv | 21 ++
 rtl/m_pc_gen_ras_stack.sv | 92 +++++++++
 rtl/m_pc_gen_ras.sv | 152 +++++++++++++++
 tb/tb_m_pc_gen_ras.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/m_pc_gen_ras_pkg.sv
// Shared constants and trace types for the fetch-stage PC generator.
// Default vectors are 32-bit; wider PC configurations override them at the top.
package m_pc_gen_ras_pkg;

   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_1000;
   localparam logic [31:0] PANIC_VEC_DEF = 32'h0000_2000;
   localparam int          INST_BYTES    = 4;

   // Which request won the next-PC arbitration this cycle (for debug/trace).
   typedef enum logic [2:0] {
      SRC_HOLD   = 3'd0,
      SRC_STALL  = 3'd1,
      SRC_EXC    = 3'd2,
      SRC_BRANCH = 3'd3,
      SRC_RET    = 3'd4,
      SRC_JUMP   = 3'd5,
      SRC_PANIC  = 3'd6,
      SRC_SEQ    = 3'd7
   } redir_src_e;

endpackage

// File: rtl/m_pc_gen_ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry, a pop of an empty stack is a no-op, replace rewrites the top in place.
module m_ras_stack
   import m_pc_gen_ras_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic            replace,
   input  logic            clear,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] top_data,
   output logic            empty,
   output logic            full
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [XLEN-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             empty_q, full_q;

   // Next storage, top pointer and occupancy from the single requested operation.
   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (clear) begin
         ptr_d = {PTR_W{1'b0}};
         cnt_d = {CNT_W{1'b0}};
      end else if (push) begin
         ptr_d        = ptr_q + PTR_ONE;
         mem_d[ptr_d] = wr_data;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else if (pop) begin
         if (cnt_q != {CNT_W{1'b0}}) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
         end
      end else if (replace) begin
         mem_d[ptr_q] = wr_data;
         if (cnt_q == {CNT_W{1'b0}}) begin
            cnt_d = CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stack state and registered flags, derived from the next count so they track it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {XLEN{1'b0}};
         end
         ptr_q   <= {PTR_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == {CNT_W{1'b0}});
         full_q  <= (cnt_d == CNT_MAX);
      end
   end

   assign top_data = mem_q[ptr_q];
   assign empty    = empty_q;
   assign full     = full_q;

endmodule

// File: rtl/m_pc_gen_ras.sv
// Fetch PC generator: prioritised redirects, fetch handshake and a return-address
// stack for call/ret prediction.
module m_pc_gen_ras
   import m_pc_gen_ras_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              BOFF_W    = 13,
   parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [XLEN-1:0] PANIC_VEC = PANIC_VEC_DEF,
   parameter int              RAS_DEPTH = 4,
   parameter bit              BR_SIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              exception,
   input  logic [XLEN-1:0]   exception_target,
   input  logic              branch,
   input  logic [BOFF_W-1:0] branch_offset,
   input  logic              jump,
   input  logic [XLEN-1:0]   jump_target,
   input  logic              call,
   input  logic              ret,
   input  logic              panic,
   input  logic              fetch_ready,
   output logic [XLEN-1:0]   pc_out,
   output logic              pc_valid,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_underflow
);

   localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q;
   logic            uf_q, uf_d;
   redir_src_e      src_s;
   logic [XLEN-1:0] boff_bytes_s;
   logic [XLEN-1:0] ret_addr_s;
   logic [XLEN-1:0] ras_top_s;
   logic            ras_empty_s, ras_full_s;
   logic            ras_push_s, ras_pop_s, ras_repl_s, ras_clr_s;

   // Word offset scaled to bytes; the legacy mode zero-extends.
   always_comb begin
      if (BR_SIGNED) begin
         boff_bytes_s = {{(XLEN-BOFF_W-2){branch_offset[BOFF_W-1]}}, branch_offset, 2'b00};
      end else begin
         boff_bytes_s = {{(XLEN-BOFF_W-2){1'b0}}, branch_offset, 2'b00};
      end
   end

   assign ret_addr_s = pc_q + INC;

   // Fixed-priority arbitration of this cycle's next-PC source.
   always_comb begin
      src_s = SRC_HOLD;
      if (exception) begin
         src_s = SRC_EXC;
      end else if (stall) begin
         src_s = SRC_STALL;
      end else if (branch) begin
         src_s = SRC_BRANCH;
      end else if (ret) begin
         src_s = SRC_RET;
      end else if (jump) begin
         src_s = SRC_JUMP;
      end else if (panic) begin
         src_s = SRC_PANIC;
      end else if (pc_valid_q && fetch_ready) begin
         src_s = SRC_SEQ;
      end else begin
         src_s = SRC_HOLD;
      end
   end

   // Next PC, underflow flag and stack operation for the winning source.
   always_comb begin
      pc_d       = pc_q;
      uf_d       = uf_q;
      ras_push_s = 1'b0;
      ras_pop_s  = 1'b0;
      ras_repl_s = 1'b0;
      ras_clr_s  = 1'b0;
      case (src_s)
         SRC_EXC:    pc_d = exception_target;
         SRC_BRANCH: pc_d = pc_q + boff_bytes_s;
         SRC_RET: begin
            if (ras_empty_s) begin
               pc_d = jump_target;
               uf_d = 1'b1;
            end else begin
               pc_d = ras_top_s;
            end
            // A simultaneous call re-uses the popped slot for its own return address.
            if (call) begin
               ras_repl_s = 1'b1;
            end else begin
               ras_pop_s = 1'b1;
            end
         end
         SRC_JUMP: begin
            pc_d       = jump_target;
            ras_push_s = call;
         end
         SRC_PANIC: begin
            pc_d      = PANIC_VEC;
            uf_d      = 1'b0;
            ras_clr_s = 1'b1;
         end
         SRC_SEQ:    pc_d = pc_q + INC;
         default:    pc_d = pc_q;
      endcase
   end

   // Architectural fetch PC, request-valid and sticky underflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_VEC;
         pc_valid_q <= 1'b0;
         uf_q       <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= 1'b1;
         uf_q       <= uf_d;
      end
   end

   m_ras_stack #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst_n    (reset),
      .push     (ras_push_s),
      .pop      (ras_pop_s),
      .replace  (ras_repl_s),
      .clear    (ras_clr_s),
      .wr_data  (ret_addr_s),
      .top_data (ras_top_s),
      .empty    (ras_empty_s),
      .full     (ras_full_s)
   );

   assign pc_out        = pc_q;
   assign pc_valid      = pc_valid_q;
   assign ras_empty     = ras_empty_s;
   assign ras_full      = ras_full_s;
   assign ras_underflow = uf_q;

endmodule

// File: tb/tb_m_pc_gen_ras.sv
// Directed bench for m_pc_gen_ras: a queue-based reference model is compared
// against the DUT every cycle, with literal expectations pinning key points.
module tb_m_pc_gen_ras;

   localparam logic [7:0] RDY = 8'h01, STL = 8'h02, EXC = 8'h04, BR  = 8'h08;
   localparam logic [7:0] JMP = 8'h10, CAL = 8'h20, RET = 8'h40, PAN = 8'h80;

   logic        clk;
   logic        reset;
   logic        stall, exception, branch, jump, call, ret, panic, fetch_ready;
   logic [31:0] exception_target, jump_target;
   logic [12:0] branch_offset;
   logic [31:0] pc_out;
   logic        pc_valid, ras_empty, ras_full, ras_underflow;

   logic [31:0] m_pc;
   logic        m_valid, m_uf;
   logic [31:0] m_ras[$];
   logic        chk_en;
   int          n_tests, n_fail;

   m_pc_gen_ras dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .exception        (exception),
      .exception_target (exception_target),
      .branch           (branch),
      .branch_offset    (branch_offset),
      .jump             (jump),
      .jump_target      (jump_target),
      .call             (call),
      .ret              (ret),
      .panic            (panic),
      .fetch_ready      (fetch_ready),
      .pc_out           (pc_out),
      .pc_valid         (pc_valid),
      .ras_empty        (ras_empty),
      .ras_full         (ras_full),
      .ras_underflow    (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0000_1000;
      m_valid = 1'b0;
      m_uf    = 1'b0;
      m_ras.delete();
   endtask

   // One clock edge of the architectural rules, applied to the current inputs.
   task automatic model_step();
      logic [31:0] old;
      old = m_pc;
      if (exception) begin
         m_pc = exception_target;
      end else if (stall) begin
         m_pc = old;
      end else if (branch) begin
         m_pc = old + 32'(int'($signed(branch_offset)) * 4);
      end else if (ret) begin
         if (m_ras.size() == 0) begin
            m_pc = jump_target;
            m_uf = 1'b1;
            if (call) m_ras.push_back(old + 32'd4);
         end else begin
            m_pc = m_ras[$];
            if (call) m_ras[$] = old + 32'd4;
            else void'(m_ras.pop_back());
         end
      end else if (jump) begin
         m_pc = jump_target;
         if (call) begin
            m_ras.push_back(old + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
         end
      end else if (panic) begin
         m_pc = 32'h0000_2000;
         m_uf = 1'b0;
         m_ras.delete();
      end else if (m_valid && fetch_ready) begin
         m_pc = old + 32'd4;
      end
      m_valid = 1'b1;
   endtask

   // Apply one cycle of requests, then return just after the following compare.
   task automatic step(input logic [7:0] f, input logic [31:0] jt = 32'h0,
                       input logic [12:0] off = 13'h0, input logic [31:0] et = 32'h0);
      fetch_ready      = f[0];
      stall            = f[1];
      exception        = f[2];
      branch           = f[3];
      jump             = f[4];
      call             = f[5];
      ret              = f[6];
      panic            = f[7];
      jump_target      = jt;
      branch_offset    = off;
      exception_target = et;
      model_step();
      @(negedge clk);
      #1;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_out", pc_out, m_pc);
         chk("pc_valid", 32'(pc_valid), 32'(m_valid));
         chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
         chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
         chk("ras_underflow", 32'(ras_underflow), 32'(m_uf));
      end
   end

   initial begin
      logic [7:0] f;
      clk = 1'b0;
      reset = 1'b0;
      chk_en = 1'b0;
      n_tests = 0;
      n_fail = 0;
      step(8'h00);
      model_reset();
      step(8'h00);
      model_reset();
      chk("rst_pc", pc_out, 32'h0000_1000);
      chk("rst_valid", 32'(pc_valid), 32'd0);
      chk("rst_empty", 32'(ras_empty), 32'd1);
      chk("rst_full", 32'(ras_full), 32'd0);
      chk("rst_uf", 32'(ras_underflow), 32'd0);
      reset = 1'b1;
      chk_en = 1'b1;

      step(RDY);
      chk("first_valid", 32'(pc_valid), 32'd1);
      chk("first_pc", pc_out, 32'h0000_1000);
      step(RDY);
      chk("seq_1004", pc_out, 32'h0000_1004);
      step(RDY);
      chk("seq_1008", pc_out, 32'h0000_1008);
      step(8'h00);
      step(8'h00);
      chk("hs_hold", pc_out, 32'h0000_1008);
      step(BR, 32'h0, 13'h1FFE);
      chk("br_neg", pc_out, 32'h0000_1000);
      repeat (4) step(RDY);
      chk("seq_1010", pc_out, 32'h0000_1010);

      step(JMP | CAL, 32'h0000_3000);
      chk("call_pc", pc_out, 32'h0000_3000);
      chk("call_nonempty", 32'(ras_empty), 32'd0);
      step(RDY);
      step(RDY);
      chk("seq_3008", pc_out, 32'h0000_3008);
      step(RET);
      chk("ret_pc", pc_out, 32'h0000_1014);
      chk("ret_empty", 32'(ras_empty), 32'd1);

      for (int i = 0; i < 5; i++) step(JMP | CAL, 32'h0000_4000 + 32'(i) * 32'h100);
      chk("five_full", 32'(ras_full), 32'd1);
      step(RET);
      chk("ret1", pc_out, 32'h0000_4304);
      step(RET);
      chk("ret2", pc_out, 32'h0000_4204);
      step(RET);
      chk("ret3", pc_out, 32'h0000_4104);
      step(RET);
      chk("ret4", pc_out, 32'h0000_4004);
      step(RET, 32'h0000_5000);
      chk("uf_pc", pc_out, 32'h0000_5000);
      chk("uf_flag", 32'(ras_underflow), 32'd1);

      step(STL | BR | JMP | RDY, 32'h0000_7000, 13'h0004);
      chk("stall_hold", pc_out, 32'h0000_5000);
      step(EXC | STL | RDY, 32'h0, 13'h0, 32'h0000_8000);
      chk("exc_pc", pc_out, 32'h0000_8000);
      step(JMP | CAL, 32'h0000_9000);
      step(RET | CAL);
      chk("retcall_pc", pc_out, 32'h0000_8004);
      step(RET);
      chk("retcall_top", pc_out, 32'h0000_9004);
      step(RET | CAL, 32'h0000_A000);
      chk("retcall_empty_pc", pc_out, 32'h0000_A000);
      chk("retcall_empty_cnt", 32'(ras_empty), 32'd0);
      step(PAN);
      chk("panic_pc", pc_out, 32'h0000_2000);
      chk("panic_empty", 32'(ras_empty), 32'd1);
      chk("panic_uf", 32'(ras_underflow), 32'd0);
      step(BR, 32'h0, 13'h0010);
      chk("br_pos", pc_out, 32'h0000_2040);
      step(JMP, 32'hFFFF_FFFC);
      step(RDY);
      chk("seq_wrap", pc_out, 32'h0000_0000);

      step(JMP | CAL, 32'h0000_B000);
      step(JMP | CAL, 32'h0000_B100);
      reset = 1'b0;
      #1;
      chk("mid_rst_pc", pc_out, 32'h0000_1000);
      chk("mid_rst_valid", 32'(pc_valid), 32'd0);
      chk("mid_rst_empty", 32'(ras_empty), 32'd1);
      model_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      step(RDY);
      step(RDY);
      chk("post_rst_pc", pc_out, 32'h0000_1004);

      for (int i = 0; i < 60; i++) begin
         f = 8'($urandom) & 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 3) != 0) f = f | RDY;
         step(f, $urandom & 32'hFFFF_FFFC, 13'($urandom), $urandom & 32'hFFFF_FFFC);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
